ps2_scan_receiver: RTL and testbench
====================================

Name: ps2_scan_receiver

Overview:
Parametrised successor to the team's single-byte PS/2 receiver. It synchronises and glitch-filters PS2C/PS2D and checks full 11-bit frames: start, odd parity, stop, and inter-edge timeout. It folds E0/F0 prefix bytes into extended and break flags on the following scan code. Decoded codes are buffered in a DEPTH-entry FIFO with a valid/ready output, so downstream logic (display, key tracker) never misses back-to-back codes.

Parameters:
SAMPLE_DIV, 250, clock cycles per sample tick (2.5 us at 100 MHz); must be >= 2
FILTER_LEN, 4, consecutive equal ticks required before the filtered PS2C changes; must be >= 2
TIMEOUT_TICKS, 800, ticks without a falling edge mid-frame before abort (2 ms)
DEPTH, 8, FIFO entries; power of two, >= 2

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
PS2C  in  1  raw PS/2 clock (async)
PS2D  in  1  raw PS/2 data (async)
out_valid  out  1  FIFO head holds a code
out_ready  in  1  consumer accepts head when out_valid=1
out_code  out  8  head scan code
out_ext  out  1  head code was preceded by E0
out_brk  out  1  head code was preceded by F0 (key release)
fifo_count  out  $clog2(DEPTH+1)  entries held
parity_err  out  1  one-cycle pulse: frame had bad parity
frame_err  out  1  one-cycle pulse: bad stop bit or timeout
overflow  out  1  one-cycle pulse: code dropped, FIFO full

Behaviour:
- Reset (synchronous, active-high): tick counter 0; filter shift register all ones; filtered clock 1; FSM IDLE; pending flags 0; FIFO empty. All outputs 0. Reset mid-frame discards the partial byte with no error pulse.
- Synchroniser: two flops on each of PS2C and PS2D, every clock.
- Tick: counter runs 0..SAMPLE_DIV-1; tick is asserted on the cycle it equals SAMPLE_DIV-1, then the counter wraps to 0.
- Filter: on each tick, shift in synced PS2C. Filtered clock takes a new value only when all FILTER_LEN samples equal it. A falling edge is filtered 1->0; data is the synced PS2D at that tick.
- FSM, stepped only on a falling edge:
  - IDLE: data 0 -> DATA with bit_cnt=0. Data 1 -> stay in IDLE, no error.
  - DATA: shift in LSB first; after the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: odd-parity check over 8 data bits plus parity. Stop bit=1 and parity ok -> byte_done. Parity bad -> parity_err. Stop bit=0 -> frame_err. Both may pulse together. Always -> IDLE.
- Timeout: outside IDLE, a tick counter clears on each falling edge. When it reaches TIMEOUT_TICKS: frame_err pulse, FSM -> IDLE, partial byte discarded.
- Prefix decode, on byte_done:
  - E0 -> set ext_pend, no push.
  - F0 -> set brk_pend, no push.
  - Any other byte, E1 included -> push {ext_pend, brk_pend, byte} and clear both pends.
  - Any parity_err, frame_err or reset clears both pends.
- Latency: let T be the cycle of the tick that samples the stop bit. byte_done is registered at T+1; the entry is visible with out_valid=1 at T+2.
- FIFO: show-ahead, 10-bit entries, count width $clog2(DEPTH+1).
  - Pop when out_valid && out_ready.
  - Push when full without a simultaneous pop -> entry dropped, overflow pulses for 1 cycle, contents unchanged.
  - Push and pop in the same cycle when full or non-empty -> both succeed.
  - Read and write pointers wrap modulo DEPTH.
  - When empty, out_valid=0 and out_code/out_ext/out_brk=0.

Decomposition:
- Package ps2_pkg:
  - state enum IDLE/DATA/PARITY/STOP
  - constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, ENTRY_W=10
  - entry field offsets
- One sub-module, ps2_code_fifo: synchronous FIFO parametrised by DEPTH and WIDTH, with push/pop/full/empty/count. Tick generation, filter, FSM and prefix decode stay in the top module.

Test Plan:
(all with SAMPLE_DIV=4, FILTER_LEN=3, TIMEOUT_TICKS=40, DEPTH=4; PS/2 half-period of 8 ticks)
1. Frame 0x1C with parity 0 -> one entry {code 1C, ext 0, brk 0}; out_valid at T+2; fifo_count=1; no error pulses.
2. Bytes E0, F0, 75 -> exactly one entry {75, ext 1, brk 1}; out_ready=1 pops it; fifo_count returns to 0.
3. F0, then 1C with parity bit 1, then 32 -> parity_err pulses once; single entry {32, ext 0, brk 0} (pend cleared).
4. out_ready=0; codes 15, 16, 17, 18, 19 -> fifo_count=4, one overflow pulse on 19, head=15. Then out_ready=1 -> pops 15, 16, 17, 18 in order.
5. In IDLE, a 1-tick low glitch on PS2C -> no FSM change, no errors. Then a start plus 4 data bits and PS2C held high -> frame_err after 40 ticks. A following good 0x1C frame is received correctly.
6. Assert reset during the DATA state of a 0x1C frame, with a pending F0 -> FIFO empty, no pulses. The next clean 1C frame gives {1C, ext 0, brk 0}.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 scan-code receiver
// Contents:
//   ps2_state_t      frame FSM states
//   PS2_EXT/PS2_BRK  prefix bytes folded into flags
//   ENTRY_*          layout of one FIFO entry {ext, brk, code}
//   odd_parity_ok    true when data plus parity bit hold an odd number of ones
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int ENTRY_W  = 10;
  localparam int CODE_LSB = 0;
  localparam int CODE_W   = 8;
  localparam int BRK_BIT  = 8;
  localparam int EXT_BIT  = 9;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_code_fifo.sv
// rtl/ps2_code_fifo.sv - show-ahead synchronous FIFO for decoded scan codes
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   push, push_data     write request and entry; ignored when full unless popping
//   pop                 consumer accepts head; ignored when empty
//   head_data           entry at the head, zero when empty
//   full, empty, count  occupancy status
module ps2_code_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scan_receiver.sv
// rtl/ps2_scan_receiver.sv - PS/2 frame receiver with prefix folding and code FIFO
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   PS2C, PS2D           raw asynchronous PS/2 clock and data
//   out_valid/out_ready  head handshake; out_code/out_ext/out_brk describe the head
//   fifo_count           entries held
//   parity_err           pulse: frame parity wrong
//   frame_err            pulse: stop bit low or mid-frame timeout
//   overflow             pulse: decoded code dropped because the FIFO was full
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int SAMPLE_DIV    = 250,
  parameter int FILTER_LEN    = 4,
  parameter int TIMEOUT_TICKS = 800,
  parameter int DEPTH         = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       PS2C,
  input  logic                       PS2D,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_code,
  output logic                       out_ext,
  output logic                       out_brk,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       parity_err,
  output logic                       frame_err,
  output logic                       overflow
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);

  logic c_meta, c_sync, d_meta, d_sync;

  always_ff @(posedge clock) begin
    c_meta <= PS2C;
    c_sync <= c_meta;
    d_meta <= PS2D;
    d_sync <= d_meta;
  end

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clock) begin
    if (reset || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Glitch filter: the filtered clock only moves once FILTER_LEN consecutive
  // samples agree, so the falling edge is decided on the newest sample.
  logic [FILTER_LEN-1:0] filt_sh;
  logic [FILTER_LEN-1:0] filt_next;
  logic                  filt_clk;
  logic                  fall;

  assign filt_next = {filt_sh[FILTER_LEN-2:0], c_sync};
  assign fall      = tick && filt_clk && (filt_next == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      filt_sh  <= '1;
      filt_clk <= 1'b1;
    end else if (tick) begin
      filt_sh <= filt_next;
      if (filt_next == '1) begin
        filt_clk <= 1'b1;
      end else if (filt_next == '0) begin
        filt_clk <= 1'b0;
      end
    end
  end

  ps2_state_t state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic       done_d, perr_d, ferr_d;
  logic [TO_W-1:0] to_cnt;
  logic       timeout;

  assign timeout = (state_q != IDLE) && (to_cnt == TO_W'(TIMEOUT_TICKS));

  always_ff @(posedge clock) begin
    if (reset || state_q == IDLE || fall) begin
      to_cnt <= '0;
    end else if (tick && !timeout) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    done_d    = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    if (timeout) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          if (!d_sync) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          shift_d   = {d_sync, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          par_d   = d_sync;
          state_d = STOP;
        end
        STOP: begin
          perr_d  = !odd_parity_ok(shift_q, par_q);
          ferr_d  = !d_sync;
          done_d  = d_sync && odd_parity_ok(shift_q, par_q);
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  logic       byte_done;
  logic [7:0] code_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      par_q      <= 1'b0;
      byte_done  <= 1'b0;
      code_q     <= 8'd0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      byte_done  <= done_d;
      parity_err <= perr_d;
      frame_err  <= ferr_d;
      if (done_d) begin
        code_q <= shift_q;
      end
    end
  end

  // Prefix bytes only arm flags; the next real code carries them into the FIFO.
  logic ext_pend, brk_pend;
  logic is_prefix;
  logic push;
  logic [ENTRY_W-1:0] entry;
  logic [ENTRY_W-1:0] head;
  logic fifo_full, fifo_empty;

  assign is_prefix = (code_q == PS2_EXT) || (code_q == PS2_BRK);
  assign push      = byte_done && !is_prefix;

  always_ff @(posedge clock) begin
    if (reset || parity_err || frame_err) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (byte_done) begin
      if (code_q == PS2_EXT) begin
        ext_pend <= 1'b1;
      end else if (code_q == PS2_BRK) begin
        brk_pend <= 1'b1;
      end else begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    entry                       = '0;
    entry[EXT_BIT]              = ext_pend;
    entry[BRK_BIT]              = brk_pend;
    entry[CODE_LSB +: CODE_W]   = code_q;
  end

  ps2_code_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (entry),
    .pop       (out_ready),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_code  = head[CODE_LSB +: CODE_W];
  assign out_ext   = head[EXT_BIT];
  assign out_brk   = head[BRK_BIT];
  assign overflow  = !reset && push && fifo_full && !(out_valid && out_ready);

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// tb/tb_ps2_scan_receiver.sv - directed self-checking bench for ps2_scan_receiver
module tb_ps2_scan_receiver;

  localparam int SD = 4;
  localparam int FL = 3;
  localparam int TO = 40;
  localparam int DP = 4;
  localparam int CW = $clog2(DP + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          PS2C = 1'b1;
  logic          PS2D = 1'b1;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [7:0]    out_code;
  logic          out_ext;
  logic          out_brk;
  logic [CW-1:0] fifo_count;
  logic          parity_err;
  logic          frame_err;
  logic          overflow;

  int checks = 0;
  int passed = 0;
  int n_perr = 0;
  int n_ferr = 0;
  int n_ovf  = 0;
  int ph;

  ps2_scan_receiver #(
    .SAMPLE_DIV(SD),
    .FILTER_LEN(FL),
    .TIMEOUT_TICKS(TO),
    .DEPTH(DP)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .PS2C       (PS2C),
    .PS2D       (PS2D),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_code   (out_code),
    .out_ext    (out_ext),
    .out_brk    (out_brk),
    .fifo_count (fifo_count),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  // Sample-tick phase: counter value during the current cycle.
  always @(posedge clock) begin
    if (reset) ph <= 0;
    else ph <= (ph == SD - 1) ? 0 : ph + 1;
  end

  always @(negedge clock) begin
    if (parity_err === 1'b1) n_perr++;
    if (frame_err === 1'b1) n_ferr++;
    if (overflow === 1'b1) n_ovf++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      PS2D = bits[i];
      repeat (16) @(posedge clock);
      #1 PS2C = 1'b0;
      repeat (32) @(posedge clock);
      #1 PS2C = 1'b1;
      repeat (16) @(posedge clock);
      #1;
    end
  endtask

  // Full frame; for the stop bit, locate the tick edge that samples it
  // and capture out_valid one and two cycles after that tick cycle.
  task automatic send_frame(input logic [7:0] b, input logic bad_par,
                            output logic v1, output logic v2, output logic found);
    logic [10:0] bits;
    int cnt;
    int k;
    bits = frame_bits(b, bad_par);
    v1 = 1'b0;
    v2 = 1'b0;
    found = 1'b0;
    send_bits(bits, 10);
    PS2D = bits[10];
    repeat (16) @(posedge clock);
    #1 PS2C = 1'b0;
    cnt = 0;
    k = 0;
    while (cnt < 3 && k < 40) begin
      @(negedge clock);
      k++;
      if (ph == SD - 1 && k >= 3) cnt++;
      @(posedge clock);
      #1;
    end
    if (cnt == 3) begin
      found = 1'b1;
      @(negedge clock);
      v1 = out_valid;
      @(negedge clock);
      v2 = out_valid;
    end
    repeat (16) @(posedge clock);
    #1 PS2C = 1'b1;
    repeat (16) @(posedge clock);
    #1 PS2D = 1'b1;
    repeat (32) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    logic a, c, f;
    send_frame(b, bad_par, a, c, f);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (4) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid);
    else passed++;
    checks++;
    if ({out_ext, out_brk, out_code} !== 10'h000)
      $display("FAIL reset_head: got %h want 000", {out_ext, out_brk, out_code});
    else passed++;
    checks++;
    if (fifo_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", fifo_count);
    else passed++;
    checks++;
    if ({parity_err, frame_err, overflow} !== 3'b000)
      $display("FAIL reset_pulses: got %b want 000", {parity_err, frame_err, overflow});
    else passed++;
  endtask

  task automatic test_single();
    int bp, bf, bo;
    logic v1, v2, f;
    bp = n_perr; bf = n_ferr; bo = n_ovf;
    send_frame(8'h1C, 1'b0, v1, v2, f);
    checks++;
    if (f !== 1'b1) $display("FAIL single_stop_tick: got %b want 1", f);
    else passed++;
    checks++;
    if ({v1, v2} !== 2'b01) $display("FAIL single_latency: valid T+1,T+2 got %b want 01", {v1, v2});
    else passed++;
    @(negedge clock);
    checks++;
    if ({out_valid, out_ext, out_brk, out_code} !== 11'h41C)
      $display("FAIL single_entry: got %h want 41c", {out_valid, out_ext, out_brk, out_code});
    else passed++;
    checks++;
    if (fifo_count !== 3'd1) $display("FAIL single_count: got %0d want 1", fifo_count);
    else passed++;
    checks++;
    if ((n_perr - bp) + (n_ferr - bf) + (n_ovf - bo) !== 0)
      $display("FAIL single_pulses: got %0d want 0", (n_perr - bp) + (n_ferr - bf) + (n_ovf - bo));
    else passed++;
    pop_one();
    @(negedge clock);
  endtask

  task automatic test_prefix();
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    @(negedge clock);
    checks++;
    if (fifo_count !== 3'd1) $display("FAIL prefix_count: got %0d want 1", fifo_count);
    else passed++;
    checks++;
    if ({out_valid, out_ext, out_brk, out_code} !== 11'h775)
      $display("FAIL prefix_entry: got %h want 775", {out_valid, out_ext, out_brk, out_code});
    else passed++;
    pop_one();
    @(negedge clock);
    checks++;
    if ({out_valid, fifo_count, out_code} !== 12'h000)
      $display("FAIL prefix_pop: got %h want 000", {out_valid, fifo_count, out_code});
    else passed++;
  endtask

  task automatic test_parity();
    int bp, bf;
    bp = n_perr; bf = n_ferr;
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b1);
    send_byte(8'h32, 1'b0);
    @(negedge clock);
    checks++;
    if (n_perr - bp !== 1) $display("FAIL parity_pulse: got %0d want 1", n_perr - bp);
    else passed++;
    checks++;
    if (n_ferr - bf !== 0) $display("FAIL parity_no_frame_err: got %0d want 0", n_ferr - bf);
    else passed++;
    checks++;
    if ({fifo_count, out_ext, out_brk, out_code} !== 13'h0432)
      $display("FAIL parity_entry: got %h want 0432", {fifo_count, out_ext, out_brk, out_code});
    else passed++;
    pop_one();
  endtask

  task automatic test_overflow();
    logic [7:0] exp_code;
    int bo;
    bo = n_ovf;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_code = 8'h15 + 8'(i);
      send_byte(exp_code, 1'b0);
    end
    @(negedge clock);
    checks++;
    if (fifo_count !== 3'd4) $display("FAIL ovf_count: got %0d want 4", fifo_count);
    else passed++;
    checks++;
    if (n_ovf - bo !== 1) $display("FAIL ovf_pulse: got %0d want 1", n_ovf - bo);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      exp_code = 8'h15 + 8'(i);
      @(negedge clock);
      checks++;
      if ({out_valid, out_ext, out_brk, out_code} !== {3'b100, exp_code})
        $display("FAIL ovf_order%0d: got %h want %h", i,
                 {out_valid, out_ext, out_brk, out_code}, {3'b100, exp_code});
      else passed++;
      pop_one();
    end
    @(negedge clock);
    checks++;
    if ({out_valid, fifo_count} !== 4'h0) $display("FAIL ovf_drain: got %h want 0", {out_valid, fifo_count});
    else passed++;
  endtask

  task automatic test_timeout();
    int bp, bf, w;
    bp = n_perr; bf = n_ferr;
    @(posedge clock);
    #1 PS2C = 1'b0;
    repeat (SD) @(posedge clock);
    #1 PS2C = 1'b1;
    repeat (64) @(posedge clock);
    #1;
    checks++;
    if ((n_perr - bp) + (n_ferr - bf) + int'(fifo_count) !== 0)
      $display("FAIL glitch_ignored: got %0d want 0", (n_perr - bp) + (n_ferr - bf) + int'(fifo_count));
    else passed++;
    send_bits(frame_bits(8'h1C, 1'b0), 5);
    PS2D = 1'b1;
    w = 0;
    while (n_ferr == bf && w < 300) begin
      @(posedge clock);
      w++;
    end
    checks++;
    if (w < 100 || w > 145) $display("FAIL timeout_delay: got %0d cycles want 100..145", w);
    else passed++;
    repeat (8) @(posedge clock);
    #1;
    checks++;
    if ({n_ferr - bf, n_perr - bp, int'(fifo_count)} !== {32'd1, 32'd0, 32'd0})
      $display("FAIL timeout_result: ferr %0d perr %0d count %0d want 1 0 0",
               n_ferr - bf, n_perr - bp, fifo_count);
    else passed++;
    send_byte(8'h1C, 1'b0);
    @(negedge clock);
    checks++;
    if ({fifo_count, out_ext, out_brk, out_code} !== 13'h041C)
      $display("FAIL timeout_recover: got %h want 041c", {fifo_count, out_ext, out_brk, out_code});
    else passed++;
    pop_one();
  endtask

  task automatic test_reset_mid();
    int bp, bf, bo;
    logic [10:0] bits;
    send_byte(8'hF0, 1'b0);
    bp = n_perr; bf = n_ferr; bo = n_ovf;
    bits = frame_bits(8'h1C, 1'b0);
    send_bits(bits, 3);
    PS2D = bits[3];
    repeat (16) @(posedge clock);
    #1 PS2C = 1'b0;
    repeat (10) @(posedge clock);
    #1 reset = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    PS2C = 1'b1;
    PS2D = 1'b1;
    reset = 1'b0;
    repeat (64) @(posedge clock);
    #1;
    checks++;
    if ({out_valid, fifo_count} !== 4'h0) $display("FAIL rstmid_empty: got %h want 0", {out_valid, fifo_count});
    else passed++;
    checks++;
    if ((n_perr - bp) + (n_ferr - bf) + (n_ovf - bo) !== 0)
      $display("FAIL rstmid_pulses: got %0d want 0", (n_perr - bp) + (n_ferr - bf) + (n_ovf - bo));
    else passed++;
    send_byte(8'h1C, 1'b0);
    @(negedge clock);
    checks++;
    if ({fifo_count, out_ext, out_brk, out_code} !== 13'h041C)
      $display("FAIL rstmid_next: got %h want 041c", {fifo_count, out_ext, out_brk, out_code});
    else passed++;
    pop_one();
  endtask

  initial begin
    test_reset();
    test_single();
    test_prefix();
    test_parity();
    test_overflow();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
